// File: rtl/md_pkg.sv
// Shared op codes and helpers for the E-stage multiply/divide unit.
package md_pkg;

   localparam int MD_OP_W = 4;

   typedef enum logic [MD_OP_W-1:0] {
      MD_NONE = 4'd0,
      MULT    = 4'd1,
      MULTU   = 4'd2,
      DIV     = 4'd3,
      DIVU    = 4'd4,
      MTHI    = 4'd5,
      MTLO    = 4'd6,
      MADD    = 4'd7,
      MADDU   = 4'd8,
      MSUB    = 4'd9,
      MSUBU   = 4'd10
   } md_op_e;

   // True for ops that occupy the unit for several cycles and finish with a done pulse.
   function automatic logic is_long(input logic [MD_OP_W-1:0] op);
      logic long_op;
      long_op = 1'b0;
      case (op)
         MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU: long_op = 1'b1;
         default: long_op = 1'b0;
      endcase
      return long_op;
   endfunction

   // Number of busy cycles for a long op; divides use their own latency.
   function automatic int lat_sel(input logic [MD_OP_W-1:0] op,
                                  input int mul_lat,
                                  input int div_lat);
      return ((op == DIV) || (op == DIVU)) ? div_lat : mul_lat;
   endfunction

endpackage

// File: rtl/md_unit_if.sv
// Operand/op request and HI/LO result bundle between the E stage and md_unit.
interface md_unit_if #(parameter int WIDTH = 32);
   import md_pkg::*;

   logic               req;
   logic               start;
   logic [MD_OP_W-1:0] op;
   logic [WIDTH-1:0]   src_a;
   logic [WIDTH-1:0]   src_b;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;

   // E-stage side: issues ops, observes status and HI/LO.
   modport master (
      output req, start, op, src_a, src_b,
      input  busy, done, hi, lo
   );

   // Unit side.
   modport slave (
      input  req, start, op, src_a, src_b,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/md_calc.sv
// Combinational arithmetic for md_unit: products, accumulation and division
// including the divide-by-zero and signed-overflow special cases.
module md_calc
   import md_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [MD_OP_W-1:0] op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [WIDTH-1:0]   hi,
   input  logic [WIDTH-1:0]   lo,
   output logic [WIDTH-1:0]   new_hi,
   output logic [WIDTH-1:0]   new_lo
);

   localparam int W2 = 2 * WIDTH;
   localparam logic [WIDTH-1:0] ZERO    = '0;
   localparam logic [WIDTH-1:0] ONES    = '1;
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   logic [W2-1:0] acc;
   logic [W2-1:0] sprod;
   logic [W2-1:0] uprod;
   logic [W2-1:0] res;

   logic                    b_zero;
   logic                    s_ovf;
   logic [WIDTH-1:0]        div_b;
   logic [WIDTH-1:0]        uq;
   logic [WIDTH-1:0]        ur;
   logic signed [WIDTH-1:0] sa;
   logic signed [WIDTH-1:0] sb;
   logic signed [WIDTH-1:0] sq;
   logic signed [WIDTH-1:0] sr;

   assign acc = {hi, lo};

   // Sign-extending to full width makes the low 2*WIDTH bits of an unsigned
   // multiply equal to the signed product.
   assign sprod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
   assign uprod = {ZERO, a} * {ZERO, b};

   // Corner cases are selected out below; the divisor is forced to 1 there so
   // the dividers never see a zero or overflowing operand pair.
   assign b_zero = (b == ZERO);
   assign s_ovf  = (a == INT_MIN) && (b == ONES);
   assign div_b  = b_zero ? ONE : b;
   assign uq     = a / div_b;
   assign ur     = a % div_b;
   assign sa     = a;
   assign sb     = (b_zero || s_ovf) ? ONE : b;
   assign sq     = sa / sb;
   assign sr     = sa % sb;

   // Select the full {hi,lo} result for the op; unknown ops leave HI/LO as they are.
   always_comb begin
      res = acc;
      case (op)
         MULT:  res = sprod;
         MULTU: res = uprod;
         MADD:  res = acc + sprod;
         MADDU: res = acc + uprod;
         MSUB:  res = acc - sprod;
         MSUBU: res = acc - uprod;
         DIV: begin
            if (b_zero)     res = {a, ONES};
            else if (s_ovf) res = {ZERO, INT_MIN};
            else            res = {sr, sq};
         end
         DIVU: begin
            if (b_zero) res = {a, ONES};
            else        res = {ur, uq};
         end
         default: res = acc;
      endcase
   end

   assign new_hi = res[W2-1:WIDTH];
   assign new_lo = res[WIDTH-1:0];

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: holds HI/LO, runs long ops for a fixed
// per-op latency and reports busy/done to the stall controller.
module md_unit
   import md_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MUL_LATENCY = 5,
   parameter int DIV_LATENCY = 10
) (
   input logic     clk,
   input logic     reset,
   md_unit_if.slave md
);

   localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   logic               busy_reg, busy_next;
   logic [CNT_W-1:0]   cnt_reg,  cnt_next;
   logic               done_reg, done_next;
   logic [MD_OP_W-1:0] op_reg,   op_next;
   logic [WIDTH-1:0]   a_reg,    a_next;
   logic [WIDTH-1:0]   b_reg,    b_next;
   logic [WIDTH-1:0]   hi_reg,   hi_next;
   logic [WIDTH-1:0]   lo_reg,   lo_next;

   logic               accept;
   logic               finish;
   logic [WIDTH-1:0]   calc_hi;
   logic [WIDTH-1:0]   calc_lo;

   // A pending exception in M or an op already in flight blocks a new start.
   assign accept = md.start && !md.req && !busy_reg && (md.op != MD_NONE);
   assign finish = busy_reg && (cnt_reg == '0);

   md_calc #(
      .WIDTH (WIDTH)
   ) u_calc (
      .op     (op_reg),
      .a      (a_reg),
      .b      (b_reg),
      .hi     (hi_reg),
      .lo     (lo_reg),
      .new_hi (calc_hi),
      .new_lo (calc_lo)
   );

   // State and datapath registers; reset discards any in-flight op at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_reg <= 1'b0;
         cnt_reg  <= '0;
         done_reg <= 1'b0;
         op_reg   <= MD_NONE;
         a_reg    <= '0;
         b_reg    <= '0;
         hi_reg   <= '0;
         lo_reg   <= '0;
      end else begin
         busy_reg <= busy_next;
         cnt_reg  <= cnt_next;
         done_reg <= done_next;
         op_reg   <= op_next;
         a_reg    <= a_next;
         b_reg    <= b_next;
         hi_reg   <= hi_next;
         lo_reg   <= lo_next;
      end
   end

   // Next state: IDLE/BUSY is the busy flag, the counter times the remaining cycles.
   always_comb begin
      busy_next = busy_reg;
      cnt_next  = cnt_reg;
      done_next = 1'b0;
      if (busy_reg) begin
         if (cnt_reg == '0) begin
            busy_next = 1'b0;
            done_next = 1'b1;
         end else begin
            cnt_next = cnt_reg - CNT_W'(1);
         end
      end else if (accept && is_long(md.op)) begin
         busy_next = 1'b1;
         cnt_next  = CNT_W'(lat_sel(md.op, MUL_LATENCY, DIV_LATENCY) - 1);
      end
   end

   // Datapath next values: latch operands on a long start, move-to writes, and
   // the result write on the completion edge (accumulates use HI/LO as held then).
   always_comb begin
      op_next = op_reg;
      a_next  = a_reg;
      b_next  = b_reg;
      hi_next = hi_reg;
      lo_next = lo_reg;
      if (accept && is_long(md.op)) begin
         op_next = md.op;
         a_next  = md.src_a;
         b_next  = md.src_b;
      end
      if (accept && (md.op == MTHI)) hi_next = md.src_a;
      if (accept && (md.op == MTLO)) lo_next = md.src_a;
      if (finish) begin
         hi_next = calc_hi;
         lo_next = calc_lo;
      end
   end

   // Outputs are straight from registers, so a read in the completion cycle sees old HI/LO.
   always_comb begin
      md.busy = busy_reg;
      md.done = done_reg;
      md.hi   = hi_reg;
      md.lo   = lo_reg;
   end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit holding the HI/LO pair; successor to the fixed-latency E-stage MD block.
- Sits in the E stage. It takes forwarded rs/rt operands and a decoded op from the E controller.
- Drives busy/done to the stall controller and HI/LO to the E-stage GRF write-data mux (mfhi/mflo).
- Adds configurable width and latency, madd/maddu/msub/msubu accumulation, defined divide-by-zero/overflow results, and exception-masked start.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_LATENCY, 5, busy cycles for mult/multu/madd*/msub* (>=1).
- DIV_LATENCY, 10, busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  M-stage exception/interrupt request; masks start in the same cycle.
- start  input  1  op valid in E this cycle.
- op  input  4  md_pkg op code.
- src_a  input  WIDTH  forwarded rs.
- src_b  input  WIDTH  forwarded rt.
- busy  output  1  long op in flight.
- done  output  1  one-cycle pulse, the cycle after HI/LO update by a long op.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=lo=0, busy=0, done=0, counter=0, operand/result buffers=0. Takes effect immediately, including mid-operation; the in-flight op is discarded.
- Accept rule: accept = start & ~req & ~busy & (op != MD_NONE).
  - start with req=1: ignored, no state change.
  - start while busy: ignored; the hazard unit must stall, but ignoring is defined behaviour.
- MTHI/MTLO: on accept, hi (resp. lo) <= src_a at that edge; busy stays 0; no done pulse.
- Long ops (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU):
  - On accept at edge k: operands and op are latched; counter <= LAT-1; busy=1 after edge k.
  - Counter decrements each edge while busy.
  - At edge k+LAT: hi/lo are written and busy falls. busy is high exactly LAT cycles.
  - done=1 for the single cycle after edge k+LAT.
- Results (full 2*WIDTH-bit {hi,lo}):
  - MULT: signed product. MULTU: unsigned product.
  - MADD/MADDU: {hi,lo} + product, signed/unsigned, mod 2^(2*WIDTH).
  - MSUB/MSUBU: {hi,lo} - product, signed/unsigned, mod 2^(2*WIDTH).
  - Accumulation uses hi/lo as they stand at the completion edge; no other write can intervene while busy.
  - DIV: lo=quotient truncated toward zero; hi=remainder carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV/DIVU): lo=all ones, hi=src_a.
  - DIV with INT_MIN / -1: lo=INT_MIN, hi=0.
- hi/lo outputs are registered values; mfhi/mflo read them combinationally through the E mux. A read in the completion cycle sees the old value; the hazard unit stalls md reads while busy.
- Counter width: $clog2(max(MUL_LATENCY,DIV_LATENCY)+1).
- LAT=1: busy high for one cycle; hi/lo updated at the next edge.
- req while busy: no effect. The in-flight op is older than the faulting instruction and completes.

Decomposition:
- md_pkg holds:
  - op codes: MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MADD=7, MADDU=8, MSUB=9, MSUBU=10;
  - MD_OP_W=4;
  - is_long(op) helper;
  - latency-select function.
- One combinational sub-module md_calc (op, a, b, hi, lo -> new_hi, new_lo). It holds all arithmetic and corner cases.
- md_unit keeps the FSM (IDLE/BUSY via the busy flag plus counter) and the registers.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=7 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
- DIVU 100/7 -> after 10 cycles lo=0x0000000E, hi=0x00000002.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x1234/0 -> hi=0x00001234, lo=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0, MTLO 0xFFFFFFFF, then MADDU 1*1 -> hi=1, lo=0.
- Then MSUB 2*3 -> hi=0, lo=0xFFFFFFFA.
- start MULT with req=1 -> busy stays 0, hi/lo unchanged.
- start DIV while busy -> ignored.
- MTHI while busy -> hi unchanged.
- reset=0 asserted 4 cycles into DIV -> busy=0, hi=lo=0 immediately, no done.
- After reset release, MULT 2*3 -> lo=6, hi=0.
